// File: rtl/qspi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qspi_pkg
// Description : Shared state encoding and default read command for the QSPI
//               cartridge ROM reader.
// Revision    : 1.0 - initial release
// ============================================================================
package qspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_DATA  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Quad I/O fast read
    localparam logic [7:0] c_DEFAULT_CMD = 8'hEB;

endpackage
`default_nettype wire

// File: rtl/qspi_rom_reader.sv
`default_nettype none
// ============================================================================
// Module      : qspi_rom_reader
// Description : Reads one byte per request from a quad-SPI flash using a
//               command/address/dummy/data frame, SPI clock at clk/2.
// Revision    : 1.0 - initial release
// ============================================================================
module qspi_rom_reader
    import qspi_pkg::*;
#(
    parameter logic [7:0]  CMD           = c_DEFAULT_CMD,
    parameter logic [23:0] ADDR_BASE     = 24'h000000,
    parameter int          DUMMY_NIBBLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [12:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        spi_sel_n,
    output logic        spi_clk,
    output logic [3:0]  spi_dout,
    output logic        spi_oe,
    input  logic [3:0]  spi_din
);

    state_t      r_state;
    logic [3:0]  r_nib_cnt;
    logic        r_phase;
    logic [31:0] r_shift;

    logic [23:0] w_flash_addr;
    logic [3:0]  w_last_cnt;
    logic        w_last;

    assign w_flash_addr = ADDR_BASE + {11'd0, req_addr};

    always_comb begin
        w_last_cnt = 4'd0;
        case (r_state)
            ST_CMD:   w_last_cnt = 4'd1;
            ST_ADDR:  w_last_cnt = 4'd5;
            ST_DUMMY: w_last_cnt = 4'(DUMMY_NIBBLES - 1);
            ST_DATA:  w_last_cnt = 4'd1;
            default:  w_last_cnt = 4'd0;
        endcase
    end

    assign w_last = (r_nib_cnt == w_last_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_nib_cnt <= 4'd0;
            r_phase   <= 1'b0;
            r_shift   <= 32'd0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'd0;
            spi_sel_n <= 1'b1;
            spi_clk   <= 1'b0;
            spi_dout  <= 4'd0;
            spi_oe    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        r_state   <= ST_CMD;
                        r_shift   <= {CMD, w_flash_addr};
                        r_nib_cnt <= 4'd0;
                        r_phase   <= 1'b0;
                        spi_sel_n <= 1'b0;
                        spi_oe    <= 1'b1;
                        spi_dout  <= CMD[7:4];
                    end
                end
                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    if (!r_phase) begin
                        r_phase <= 1'b1;
                        spi_clk <= 1'b1;
                    end else begin
                        // End of a nibble: advance the frame by one nibble
                        r_phase   <= 1'b0;
                        spi_clk   <= 1'b0;
                        r_nib_cnt <= w_last ? 4'd0 : r_nib_cnt + 4'd1;
                        if (r_state == ST_DATA)
                            r_shift <= {r_shift[27:0], spi_din};
                        else
                            r_shift <= r_shift << 4;
                        case (r_state)
                            ST_CMD: begin
                                spi_dout <= r_shift[27:24];
                                if (w_last)
                                    r_state <= ST_ADDR;
                            end
                            ST_ADDR: begin
                                if (w_last) begin
                                    r_state  <= ST_DUMMY;
                                    spi_oe   <= 1'b0;
                                    spi_dout <= 4'd0;
                                end else begin
                                    spi_dout <= r_shift[27:24];
                                end
                            end
                            ST_DUMMY: begin
                                if (w_last)
                                    r_state <= ST_DATA;
                            end
                            ST_DATA: begin
                                if (w_last) begin
                                    r_state   <= ST_DONE;
                                    spi_sel_n <= 1'b1;
                                    rsp_valid <= 1'b1;
                                    rsp_data  <= {r_shift[3:0], spi_din};
                                end
                            end
                            default: r_state <= ST_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qspi_rom_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_qspi_rom_reader
// Description : Self-checking bench for qspi_rom_reader with a nibble-level
//               flash ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qspi_rom_reader;

    localparam int c_LAT = 2 * (10 + 4);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [12:0] req_addr = 13'd0;
    logic        req_ready, rsp_valid, spi_sel_n, spi_clk, spi_oe;
    logic [7:0]  rsp_data;
    logic [3:0]  spi_dout;
    logic [3:0]  spi_din;

    logic        ready2, rv2, sel2, clk2, oe2;
    logic [7:0]  rd2;
    logic [3:0]  dout2;
    logic [3:0]  din2 = 4'h0;

    qspi_rom_reader dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .spi_sel_n(spi_sel_n), .spi_clk(spi_clk), .spi_dout(spi_dout),
        .spi_oe(spi_oe), .spi_din(spi_din)
    );

    qspi_rom_reader #(.ADDR_BASE(24'hFFFFF0)) dut_base (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(ready2), .rsp_valid(rv2), .rsp_data(rd2),
        .spi_sel_n(sel2), .spi_clk(clk2), .spi_dout(dout2),
        .spi_oe(oe2), .spi_din(din2)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rom_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // Flash model: records driven nibbles, returns ROM data in the DATA slots
    int          nib_idx = 0;
    int          drv_cnt = 0;
    int          first_undrv = -1;
    int          dout_err = 0;
    logic [31:0] word = 32'd0;
    logic [31:0] word2 = 32'd0;
    logic [7:0]  rom_q;

    assign rom_q = rom_byte(word[23:0]);

    always @(negedge clk) begin
        if (spi_sel_n) begin
            nib_idx <= 0;
        end else if (!spi_clk) begin
            if (nib_idx == 0) begin
                word        <= 32'd0;
                drv_cnt     <= 0;
                first_undrv <= -1;
            end
            spi_din <= (nib_idx == 12) ? rom_q[7:4] :
                       (nib_idx == 13) ? rom_q[3:0] : 4'hC;
        end else begin
            nib_idx <= nib_idx + 1;
            if (spi_oe) begin
                word    <= {word[27:0], spi_dout};
                drv_cnt <= drv_cnt + 1;
            end else if (first_undrv < 0) begin
                first_undrv <= nib_idx;
            end
        end
        if (!spi_oe && spi_dout != 4'd0)
            dout_err <= dout_err + 1;
    end

    always @(negedge clk) begin
        if (!sel2 && clk2 && oe2)
            word2 <= {word2[27:0], dout2};
    end

    typedef struct {
        logic [12:0] addr;
        logic [23:0] exp_addr;
        logic [23:0] exp_addr2;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic run_req(input logic [12:0] a, input bit disturb,
                           output int lat, output bit ok);
        int guard;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100)
            check("ready_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        ok  = 1'b0;
        while (lat < 60) begin
            @(posedge clk);
            lat++;
            #1;
            if (disturb && lat >= 24 && lat < 28) begin
                req_valid = lat[0];
                req_addr  = ~a;
            end
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        req_valid = 1'b0;
        check("rsp_seen", 32'(ok), 32'd1);
    endtask

    initial begin
        int  lat;
        bit  ok;
        int  edges;
        int  cnt;

        vecs[0] = '{13'h0000, 24'h000000, 24'hFFFFF0, 8'hA5};
        vecs[1] = '{13'h0123, 24'h000123, 24'h000113, 8'h87};
        vecs[2] = '{13'h1FFF, 24'h001FFF, 24'h001FEF, 8'h45};
        vecs[3] = '{13'h0A5C, 24'h000A5C, 24'h000A4C, 8'hF3};
        vecs[4] = '{13'h1000, 24'h001000, 24'h000FF0, 8'hB5};
        vecs[5] = '{13'h0020, 24'h000020, 24'h000010, 8'h85};

        repeat (3) @(negedge clk);
        check("rst_sel_n",     32'(spi_sel_n), 32'd1);
        check("rst_spi_clk",   32'(spi_clk),   32'd0);
        check("rst_oe",        32'(spi_oe),    32'd0);
        check("rst_dout",      32'(spi_dout),  32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(rsp_data),  32'd0);
        check("rst_ready",     32'(req_ready), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("ready_after_rst", 32'(req_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            run_req(vecs[i].addr, (i == 3), lat, ok);
            check("latency",     32'(lat),         32'(c_LAT));
            check("rsp_data",    32'(rsp_data),    32'(vecs[i].exp_data));
            check("frame_word",  word,             {8'hEB, vecs[i].exp_addr});
            check("oe_fall_nib", 32'(first_undrv), 32'd8);
            check("drv_nibbles", 32'(drv_cnt),     32'd8);
            check("base_word",   word2,            {8'hEB, vecs[i].exp_addr2});
            check("done_sel_n",  32'(spi_sel_n),   32'd1);
            @(posedge clk);
            #1;
            check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
            check("rsp_hold",      32'(rsp_data),  32'(vecs[i].exp_data));
        end

        // Back-to-back with req_valid held high
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 13'h0123;
        edges = 0;
        while (!req_ready && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        @(posedge clk);
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            lat++;
            #1;
            if (rsp_valid) break;
        end
        check("b2b_lat1",  32'(lat),      32'(c_LAT));
        check("b2b_data1", 32'(rsp_data), 32'h87);
        req_addr = 13'h0A5C;
        edges = 0;
        while (spi_sel_n && edges < 10) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("b2b_accept_gap", 32'(edges), 32'd2);
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            lat++;
            #1;
            if (rsp_valid) break;
        end
        req_valid = 1'b0;
        check("b2b_lat2",  32'(lat),      32'(c_LAT));
        check("b2b_data2", 32'(rsp_data), 32'hF3);
        check("b2b_word2", word,          32'hEB000A5C);

        // Reset asserted in the middle of the dummy phase
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 13'h1FFF;
        edges = 0;
        while (!req_ready && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        check("sel_low_pre_rst", 32'(spi_sel_n), 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_sel_n",   32'(spi_sel_n), 32'd1);
        check("async_oe",      32'(spi_oe),    32'd0);
        check("async_ready",   32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (rsp_valid) cnt++;
        end
        check("no_rsp_after_rst", 32'(cnt), 32'd0);
        run_req(13'h1000, 1'b0, lat, ok);
        check("post_rst_lat",  32'(lat),      32'(c_LAT));
        check("post_rst_data", 32'(rsp_data), 32'hB5);
        check("post_rst_word", word,          32'hEB001000);

        check("dout_zero_when_undriven", 32'(dout_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
